// File: rtl/channel_if.sv
// Sender/receiver bundled-data link signals for the channel block.
// master = environment side (sender + receiver agents), slave = channel.
interface channel_if #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 32
);
    logic                 s_req;
    logic [WIDTH-1:0]     s_data;
    logic                 s_ack;
    logic                 r_req;
    logic [WIDTH-1:0]     r_data;
    logic                 r_ack;
    logic                 busy;
    logic [CNT_WIDTH-1:0] xfer_count;
    logic                 proto_err;

    modport master (
        output s_req, s_data, r_ack,
        input  s_ack, r_req, r_data, busy, xfer_count, proto_err
    );

    modport slave (
        input  s_req, s_data, r_ack,
        output s_ack, r_req, r_data, busy, xfer_count, proto_err
    );
endinterface

// File: rtl/channel.sv
// Purpose: point-to-point bundled-data link, 4-phase or 2-phase, with transfer counter and sticky error.
// Latency: one clock per hop; an input sampled at edge n is visible on the outputs after edge n.
// Backpressure: a new request is taken only in IDLE; the sender is held until the receiver acknowledges.
module channel #(
    parameter int WIDTH       = 64,
    parameter int HS_PROTOCOL = 0,
    parameter int CNT_WIDTH   = 32
) (
    input  logic     clk,
    input  logic     rst,
    channel_if.slave link
);
    // In 2-phase mode REQ doubles as the WAIT state; ACK and RTZ are unused there.
    typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} stateT;

    stateT                stateQ, stateD;
    logic                 sAckQ, sAckD;
    logic                 rReqQ, rReqD;
    logic [WIDTH-1:0]     rDataQ, rDataD;
    logic [CNT_WIDTH-1:0] cntQ, cntD;
    logic                 errQ, errD;
    logic                 busyQ;
    logic                 rAckQ;

    always_comb begin
        stateD = stateQ;
        sAckD  = sAckQ;
        rReqD  = rReqQ;
        rDataD = rDataQ;
        cntD   = cntQ;
        errD   = errQ;
        if (HS_PROTOCOL == 0) begin
            case (stateQ)
                IDLE: begin
                    if (link.s_req) begin
                        rDataD = link.s_data;
                        rReqD  = 1'b1;
                        stateD = REQ;
                    end
                    if (link.r_ack) errD = 1'b1;
                end
                REQ: begin
                    if (link.r_ack) begin
                        sAckD  = 1'b1;
                        cntD   = cntQ + CNT_WIDTH'(1);
                        stateD = ACK;
                    end else if (!link.s_req) begin
                        errD = 1'b1;
                    end
                end
                ACK: begin
                    if (!link.s_req) begin
                        rReqD  = 1'b0;
                        stateD = RTZ;
                    end
                end
                RTZ: begin
                    if (!link.r_ack) begin
                        sAckD  = 1'b0;
                        stateD = IDLE;
                    end
                end
                default: stateD = IDLE;
            endcase
        end else begin
            // r_req and s_ack are phase bits: a request is pending while they differ from their partner.
            if (stateQ == IDLE) begin
                if (link.s_req != sAckQ) begin
                    rDataD = link.s_data;
                    rReqD  = ~rReqQ;
                    stateD = REQ;
                end
                if (link.r_ack != rAckQ) errD = 1'b1;
            end else begin
                if (link.r_ack == rReqQ) begin
                    sAckD  = ~sAckQ;
                    cntD   = cntQ + CNT_WIDTH'(1);
                    stateD = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            sAckQ  <= 1'b0;
            rReqQ  <= 1'b0;
            rDataQ <= '0;
            cntQ   <= '0;
            errQ   <= 1'b0;
            busyQ  <= 1'b0;
            rAckQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            sAckQ  <= sAckD;
            rReqQ  <= rReqD;
            rDataQ <= rDataD;
            cntQ   <= cntD;
            errQ   <= errD;
            busyQ  <= (stateD != IDLE);
            rAckQ  <= link.r_ack;
        end
    end

    assign link.s_ack      = sAckQ;
    assign link.r_req      = rReqQ;
    assign link.r_data     = rDataQ;
    assign link.xfer_count = cntQ;
    assign link.proto_err  = errQ;
    assign link.busy       = busyQ;
endmodule

// File: tb/tb_channel.sv
// Bench for channel: one 4-phase and one 2-phase instance driven by sender/receiver agents,
// with a queue scoreboard checking every packet delivered on the receiver side.
module tb_channel;
    localparam int W  = 64;
    localparam int CW = 32;

    logic clk;
    logic rst;

    channel_if #(.WIDTH(W), .CNT_WIDTH(CW)) ifc4 ();
    channel_if #(.WIDTH(W), .CNT_WIDTH(CW)) ifc2 ();

    channel #(.WIDTH(W), .HS_PROTOCOL(0), .CNT_WIDTH(CW)) u4 (.clk(clk), .rst(rst), .link(ifc4));
    channel #(.WIDTH(W), .HS_PROTOCOL(1), .CNT_WIDTH(CW)) u2 (.clk(clk), .rst(rst), .link(ifc2));

    int nChecks = 0;
    int nFails  = 0;

    logic [W-1:0] exp4[$];
    logic [W-1:0] exp2[$];
    int           cnt4 = 0;
    int           cnt2 = 0;
    logic         rxAuto4 = 1'b0;
    int           rxDelay4 = 2;
    logic         rx2En = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Scoreboard for the 4-phase link: pop on every r_req rise, then require r_data to hold.
    initial begin
        logic         prev = 1'b0;
        logic [W-1:0] cur  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifc4.r_req && !prev) begin
                    check("sb4_nonempty", 64'(exp4.size() != 0), 64'd1);
                    if (exp4.size() != 0) begin
                        cur = exp4.pop_front();
                        check("r_data4", ifc4.r_data, cur);
                    end
                end else if (ifc4.r_req) begin
                    check("r_data4_hold", ifc4.r_data, cur);
                end
            end
            prev = ifc4.r_req;
        end
    end

    // Scoreboard for the 2-phase link: every r_req toggle is one delivered packet.
    initial begin
        logic prev  = 1'b0;
        logic phase = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 1'b0;
            end else if (ifc2.r_req != prev) begin
                phase = ~phase;
                check("r_req2_phase", 64'(ifc2.r_req), 64'(phase));
                check("sb2_nonempty", 64'(exp2.size() != 0), 64'd1);
                if (exp2.size() != 0) check("r_data2", ifc2.r_data, exp2.pop_front());
            end
            prev = ifc2.r_req;
        end
    end

    // 4-phase receiver agent.
    initial begin
        ifc4.r_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rxAuto4 && !rst && ifc4.r_req && !ifc4.r_ack) begin
                int d;
                d = (rxDelay4 >= 0) ? rxDelay4 : int'($urandom_range(0, 3));
                repeat (d) @(negedge clk);
                ifc4.r_ack = 1'b1;
                for (int i = 0; i < 100 && ifc4.r_req; i++) @(negedge clk);
                ifc4.r_ack = 1'b0;
            end
        end
    end

    // 2-phase receiver agent.
    initial begin
        ifc2.r_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rx2En && !rst && ifc2.r_req != ifc2.r_ack) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ifc2.r_ack = ifc2.r_req;
            end
        end
    end

    task automatic send4(input logic [W-1:0] d);
        @(negedge clk);
        ifc4.s_data = d;
        ifc4.s_req  = 1'b1;
        exp4.push_back(d);
        @(negedge clk);
        ifc4.s_data = {$urandom, $urandom};
        for (int i = 0; i < 100 && !ifc4.s_ack; i++) @(negedge clk);
        check("s_ack4_rise", 64'(ifc4.s_ack), 64'd1);
        cnt4++;
        check("xfer_count4", 64'(ifc4.xfer_count), 64'(cnt4));
        ifc4.s_req = 1'b0;
        for (int i = 0; i < 100 && ifc4.s_ack; i++) @(negedge clk);
        check("s_ack4_fall", 64'(ifc4.s_ack), 64'd0);
        check("r_req4_rtz", 64'(ifc4.r_req), 64'd0);
        check("proto_err4_clean", 64'(ifc4.proto_err), 64'd0);
    endtask

    task automatic send2(input logic [W-1:0] d);
        @(negedge clk);
        ifc2.s_data = d;
        ifc2.s_req  = ~ifc2.s_req;
        exp2.push_back(d);
        @(negedge clk);
        ifc2.s_data = {$urandom, $urandom};
        for (int i = 0; i < 100 && ifc2.s_ack != ifc2.s_req; i++) @(negedge clk);
        check("s_ack2_phase", 64'(ifc2.s_ack), 64'(ifc2.s_req));
        cnt2++;
        check("xfer_count2", 64'(ifc2.xfer_count), 64'(cnt2));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst         = 1'b1;
        ifc4.s_req  = 1'b0;
        ifc4.r_ack  = 1'b0;
        ifc2.s_req  = 1'b0;
        ifc2.r_ack  = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        cnt4 = 0;
    endtask

    task automatic checkIdle4(input string tag);
        check({tag, "_s_ack"},     64'(ifc4.s_ack),      64'd0);
        check({tag, "_r_req"},     64'(ifc4.r_req),      64'd0);
        check({tag, "_r_data"},    ifc4.r_data,          64'd0);
        check({tag, "_busy"},      64'(ifc4.busy),       64'd0);
        check({tag, "_xfer"},      64'(ifc4.xfer_count), 64'd0);
        check({tag, "_proto_err"}, 64'(ifc4.proto_err),  64'd0);
    endtask

    initial begin
        logic [3:0] nib[5] = '{4'h1, 4'h5, 4'h3, 4'h7, 4'hC};
        rst         = 1'b1;
        ifc4.s_req  = 1'b0;
        ifc4.s_data = '0;
        ifc2.s_req  = 1'b0;
        ifc2.s_data = '0;
        repeat (3) @(negedge clk);
        checkIdle4("rst4");
        check("rst2_r_req", 64'(ifc2.r_req), 64'd0);
        check("rst2_s_ack", 64'(ifc2.s_ack), 64'd0);
        check("rst2_xfer",  64'(ifc2.xfer_count), 64'd0);
        rst = 1'b0;

        // Single 4-phase packet, receiver acks two cycles after r_req.
        rxAuto4  = 1'b1;
        rxDelay4 = 2;
        send4(64'h0100_0000_0000_000A);
        check("single_r_data_held", ifc4.r_data, 64'h0100_0000_0000_000A);

        // Stream of five, then random packets with random receiver latency.
        rxDelay4 = -1;
        for (int i = 0; i < 5; i++) send4((64'(nib[i]) << 56) | 64'h0A);
        for (int i = 0; i < 8; i++) send4({$urandom, $urandom});
        check("stream_count", 64'(ifc4.xfer_count), 64'd14);

        // 2-phase: three transfers by toggling s_req.
        rx2En = 1'b1;
        for (int i = 0; i < 3; i++) send2({$urandom, $urandom});
        repeat (2) @(negedge clk);
        check("p2_s_ack_end", 64'(ifc2.s_ack), 64'd1);
        check("p2_r_req_end", 64'(ifc2.r_req), 64'd1);
        check("p2_xfer_end",  64'(ifc2.xfer_count), 64'd3);
        check("p2_proto_err", 64'(ifc2.proto_err), 64'd0);
        rx2En = 1'b0;

        // Violation: s_req dropped while waiting for r_ack; handshake still completes.
        rxAuto4 = 1'b0;
        @(negedge clk);
        ifc4.s_data = 64'hDEAD_BEEF_0000_0001;
        ifc4.s_req  = 1'b1;
        exp4.push_back(64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        check("viol_busy", 64'(ifc4.busy), 64'd1);
        ifc4.s_req = 1'b0;
        @(negedge clk);
        check("viol_sreq_err", 64'(ifc4.proto_err), 64'd1);
        ifc4.r_ack = 1'b1;
        for (int i = 0; i < 50 && !ifc4.s_ack; i++) @(negedge clk);
        check("viol_s_ack", 64'(ifc4.s_ack), 64'd1);
        cnt4++;
        check("viol_xfer", 64'(ifc4.xfer_count), 64'(cnt4));
        for (int i = 0; i < 50 && ifc4.r_req; i++) @(negedge clk);
        ifc4.r_ack = 1'b0;
        for (int i = 0; i < 50 && ifc4.s_ack; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("viol_sticky", 64'(ifc4.proto_err), 64'd1);
        check("viol_idle",   64'(ifc4.busy), 64'd0);
        doReset();
        check("viol_cleared", 64'(ifc4.proto_err), 64'd0);

        // Violation: r_ack pulse while IDLE.
        ifc4.r_ack = 1'b1;
        @(negedge clk);
        ifc4.r_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_err", 64'(ifc4.proto_err), 64'd1);
        repeat (4) @(negedge clk);
        check("idle_ack_sticky", 64'(ifc4.proto_err), 64'd1);
        doReset();
        checkIdle4("rst_after_err");

        // Reset while in ACK aborts the transfer; a following transfer completes normally.
        @(negedge clk);
        ifc4.s_data = 64'h0123_4567_89AB_CDEF;
        ifc4.s_req  = 1'b1;
        exp4.push_back(64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 50 && !ifc4.r_req; i++) @(negedge clk);
        check("ack_rst_r_req", 64'(ifc4.r_req), 64'd1);
        ifc4.r_ack = 1'b1;
        for (int i = 0; i < 50 && !ifc4.s_ack; i++) @(negedge clk);
        check("ack_rst_s_ack", 64'(ifc4.s_ack), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        checkIdle4("rst_in_ack");
        ifc4.s_req = 1'b0;
        ifc4.r_ack = 1'b0;
        rst  = 1'b0;
        cnt4 = 0;
        rxAuto4  = 1'b1;
        rxDelay4 = 1;
        send4(64'h0200_0000_0000_000A);
        check("post_rst_xfer", 64'(ifc4.xfer_count), 64'd1);
        repeat (4) @(negedge clk);
        check("sb4_drained", 64'(exp4.size()), 64'd0);
        check("sb2_drained", 64'(exp2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end
endmodule
